// File: rtl/fdiv_pkg.sv
// Shared types and constants for the divider's post-multiply stage:
// IEEE-754 single-precision field limits and the operand sideband record.
package fdiv_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef struct packed {
    logic       s;
    logic [7:0] ex;
    logic [7:0] ey;
    logic       rz;
    logic       xz;
    logic       yz;
    logic       xi;
    logic       yi;
  } fdiv_side_t;

  typedef struct packed {
    logic zero;
    logic inf;
  } fdiv_cls_t;

  // Denormals count as zero, and any all-ones exponent counts as inf (NaN inputs included).
  function automatic fdiv_cls_t classify(input logic [7:0] e);
    fdiv_cls_t c;
    c.zero = (e == 8'h00);
    c.inf  = (e == 8'hFF);
    return c;
  endfunction

endpackage

// File: rtl/fdiv_side_delay.sv
// Shift register carrying {valid, sideband} alongside the mantissa multiplier.
// An asynchronous clear drops every in-flight entry.
module fdiv_side_delay
  import fdiv_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       valid_i,
  input  fdiv_side_t side_i,
  output logic       valid_o,
  output fdiv_side_t side_o
);

  logic [DEPTH-1:0] valid_q;
  fdiv_side_t       side_q [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) side_q[i] <= '0;
    end else begin
      valid_q[0] <= valid_i;
      side_q[0]  <= side_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        side_q[i]  <= side_q[i-1];
      end
    end
  end

  assign valid_o = valid_q[DEPTH-1];
  assign side_o  = side_q[DEPTH-1];

endmodule

// File: rtl/fdiv_post_pipe.sv
// Final divider stage: aligns x/y sideband with the multiplier product p and
// registers the IEEE single quotient, handling signs, exponent and specials.
module fdiv_post_pipe
  import fdiv_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [31:0] p,
  output logic        out_valid,
  output logic [31:0] res
);

  // Handshake: no ready. in_valid marks x/y in the cycle the multiplier takes
  // them. p is only used MUL_LAT cycles later. out_valid pulses for one cycle,
  // MUL_LAT+1 cycles after in_valid. res holds its value between pulses.

  fdiv_side_t side_in, side_dly;
  fdiv_cls_t  cls_x, cls_y;
  logic       valid_dly;

  always_comb begin
    cls_x      = classify(x[30:23]);
    cls_y      = classify(y[30:23]);
    side_in    = '0;
    side_in.s  = x[31] ^ y[31];
    side_in.ex = x[30:23];
    side_in.ey = y[30:23];
    side_in.rz = (y[22:0] == 23'd0);
    side_in.xz = cls_x.zero;
    side_in.yz = cls_y.zero;
    side_in.xi = cls_x.inf;
    side_in.yi = cls_y.inf;
  end

  fdiv_side_delay #(
    .DEPTH (MUL_LAT)
  ) u_side_delay (
    .clk     (clk),
    .rstn    (rstn),
    .valid_i (in_valid),
    .side_i  (side_in),
    .valid_o (valid_dly),
    .side_o  (side_dly)
  );

  // Ten bits in two's complement cover every value from -129 to 383.
  // An exact reciprocal (my==0) keeps its exponent. Any other reciprocal
  // mantissa lies in (0.5,1), so it takes one off the exponent.
  logic [9:0]  e_sum;
  logic        e_neg, e_over, e_under;
  logic [31:0] res_d;

  always_comb begin
    e_sum   = {2'b00, side_dly.ex} - {2'b00, side_dly.ey} + 10'(EXP_BIAS)
            + {2'b00, p[30:23]} - 10'(EXP_BIAS) - {9'd0, ~side_dly.rz};
    e_neg   = e_sum[9];
    e_over  = !e_neg && (e_sum >= 10'(EXP_MAX));
    e_under = e_neg || (e_sum == 10'd0);

    if ((side_dly.xz && side_dly.yz) || (side_dly.xi && side_dly.yi)) begin
      res_d = QNAN;
    end else if (side_dly.xi || side_dly.yz) begin
      res_d = {side_dly.s, POS_INF[30:0]};
    end else if (side_dly.xz || side_dly.yi) begin
      res_d = {side_dly.s, 31'd0};
    end else if (e_over) begin
      res_d = {side_dly.s, POS_INF[30:0]};
    end else if (e_under) begin
      res_d = {side_dly.s, 31'd0};
    end else begin
      res_d = {side_dly.s, e_sum[7:0], p[22:0]};
    end
  end

  logic        out_valid_q;
  logic [31:0] res_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      out_valid_q <= valid_dly;
      if (valid_dly) res_q <= res_d;
    end
  end

  assign out_valid = out_valid_q;
  assign res       = res_q;

endmodule

// File: tb/tb_fdiv_post_pipe.sv
// Bench for fdiv_post_pipe: the driver feeds directed vectors with p delayed by
// MUL_LAT cycles, and a negedge monitor pops expected results and issue cycles.
module tb_fdiv_post_pipe;

  localparam int MUL_LAT = 2;

  logic        clk;
  logic        rstn;
  logic        in_valid;
  logic [31:0] x, y, p;
  logic        out_valid;
  logic [31:0] res;

  fdiv_post_pipe #(
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .x         (x),
    .y         (y),
    .p         (p),
    .out_valid (out_valid),
    .res       (res)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          cyc_q[$];
  logic [31:0] p_line [MUL_LAT];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [31:0] xv, input logic [31:0] yv,
                       input logic [31:0] pv, input logic [31:0] expv);
    @(negedge clk);
    p = p_line[MUL_LAT-1];
    for (int i = MUL_LAT - 1; i > 0; i--) p_line[i] = p_line[i-1];
    p_line[0] = v ? pv : $urandom;
    in_valid  = v;
    x         = v ? xv : $urandom;
    y         = v ? yv : $urandom;
    if (v) begin
      exp_q.push_back(expv);
      cyc_q.push_back(cyc + 1);
    end
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      idle();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rstn && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got out_valid=1 res=0x%08h, expected no result", res);
      end else begin
        logic [31:0] e;
        int          c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("res", res, e);
        check("latency", 32'(cyc), 32'(c + MUL_LAT));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    x        = '0;
    y        = '0;
    p        = '0;
    for (int i = 0; i < MUL_LAT; i++) p_line[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_res", res, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic arithmetic
    drive(1'b1, 32'h40C0_0000, 32'h4000_0000, 32'h3FC0_0000, 32'h4040_0000); // 6/2
    drain();
    drive(1'b1, 32'h3F80_0000, 32'h4040_0000, 32'h3FAA_AAAB, 32'h3EAA_AAAB); // 1/3
    drive(1'b1, 32'hBF80_0000, 32'h4040_0000, 32'h3FAA_AAAB, 32'hBEAA_AAAB); // -1/3
    drive(1'b1, 32'h4000_0000, 32'h3FC0_0000, 32'h3FAA_AAAB, 32'h3FAA_AAAB); // 2/1.5
    drive(1'b1, 32'h4040_0000, 32'h3FC0_0000, 32'h4000_0000, 32'h4000_0000); // 3/1.5, ep=128
    drive(1'b1, 32'hC0C0_0000, 32'h4000_0000, 32'hBFC0_0000, 32'hC040_0000); // -6/2, p sign ignored
    // Range limits
    drive(1'b1, 32'h7F00_0000, 32'h3E80_0000, 32'h3F80_0000, 32'h7F80_0000); // overflow
    drive(1'b1, 32'h0080_0000, 32'h4000_0000, 32'h3F80_0000, 32'h0000_0000); // underflow
    // Specials
    drive(1'b1, 32'h0000_0000, 32'h0000_0000, 32'h3F80_0000, 32'h7FC0_0000); // 0/0
    drive(1'b1, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0000, 32'h7F80_0000); // 1/0
    drive(1'b1, 32'hBF80_0000, 32'h7F80_0000, 32'h3F80_0000, 32'h8000_0000); // -1/inf
    drive(1'b1, 32'h0040_0000, 32'h3F80_0000, 32'h3FC0_0000, 32'h0000_0000); // denormal/1
    drive(1'b1, 32'h7F80_0000, 32'hFF80_0000, 32'h3F80_0000, 32'h7FC0_0000); // inf/-inf
    drive(1'b1, 32'hFF80_0000, 32'h4000_0000, 32'h3F80_0000, 32'hFF80_0000); // -inf/2
    drain();

    // Streaming: 8 back-to-back, 2 bubbles, 3 more. x = +-2^(e-127), y = 2.0.
    for (int i = 0; i < 11; i++) begin
      logic [7:0]  ex;
      logic [22:0] pm;
      logic        sx;
      if (i == 8) begin
        idle();
        idle();
      end
      ex = 8'(120 + i);
      pm = 23'(i * 32'h11111);
      sx = i[0];
      drive(1'b1, {sx, ex, 23'd0}, 32'h4000_0000, {1'b0, 8'd127, pm},
            {sx, 8'(119 + i), pm});
    end
    drain();

    // Reset while two entries are in flight
    drive(1'b1, 32'h40C0_0000, 32'h4000_0000, 32'h3FC0_0000, 32'h4040_0000);
    drive(1'b1, 32'h3F80_0000, 32'h4040_0000, 32'h3FAA_AAAB, 32'h3EAA_AAAB);
    idle();
    @(posedge clk);
    #2;
    check("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    rstn = 1'b0;
    #1;
    check("async_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_res", res, 32'd0);
    exp_q.delete();
    cyc_q.delete();
    for (int i = 0; i < MUL_LAT; i++) p_line[i] = $urandom;
    idle();
    idle();
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle();
      check("post_reset_quiet", {31'd0, out_valid}, 32'd0);
    end

    // Recovery after reset
    drive(1'b1, 32'h3F80_0000, 32'h4040_0000, 32'h3FAA_AAAB, 32'h3EAA_AAAB);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fdiv_post_pipe.md
Name: fdiv_post_pipe

Overview:
- Final stage of the pipelined Newton-Raphson divider. Sits directly downstream of the divider's mantissa multiplier.
- The multiplier delivers p = 1.mx * 1.mr (reciprocal mantissa of y) as a float with sign 0 and exponent 127 or 128.
- This block time-aligns the original operands x, y with p, computes sign, exponent and special cases, and registers the IEEE-754 single-precision quotient x/y.
- Fully pipelined: one result per cycle, no backpressure.

Parameters:
- MUL_LAT, 1, cycles between operands entering the multiplier and p being valid (legal 1..4).

Ports:
- clk  input  1  clock
- rstn  input  1  reset
- in_valid  input  1  x,y valid; asserted in the same cycle the multiplier receives its operands
- x  input  32  dividend (IEEE single)
- y  input  32  divisor (IEEE single)
- p  input  32  multiplier result, valid exactly MUL_LAT cycles after in_valid; sign bit ignored
- out_valid  output  1  res valid
- res  output  32  quotient

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rstn).
- Reset values: out_valid=0, res=0, all internal valid and sideband registers 0.
- Reset asserted mid-operation clears every in-flight entry immediately. No out_valid pulse may follow reset release for data accepted before reset.
- Sideband delay, captured at in_valid and shifted every cycle for MUL_LAT stages:
  - s = sx^sy
  - ex, ey (8b each)
  - rz = (my==0)
  - class flags: xz = (ex==0), yz = (ey==0), xi = (ex==255), yi = (ey==255)
- Denormals are treated as zero; ex==255 is treated as inf regardless of mantissa.
- Combine, in the cycle the delayed entry meets p:
  - ep = p[30:23]
  - E = ex - ey + 127 + (ep - 127) - (rz ? 0 : 1), evaluated as signed 10-bit
  - Mantissa = p[22:0], taken unchanged (rounding is owned by the multiplier).
- Special-case priority, first match wins:
  1. (xz&yz) or (xi&yi) -> 0x7FC00000 (qNaN, sign 0)
  2. xi or yz -> {s, 0xFF, 23'b0}
  3. xz or yi -> {s, 31'b0}
  4. E >= 255 -> {s, 0xFF, 23'b0} (overflow)
  5. E <= 0 -> {s, 31'b0} (underflow, flush to zero)
  6. otherwise -> {s, E[7:0], p[22:0]}
- Output register: res and out_valid are registered. Latency from in_valid to out_valid is exactly MUL_LAT+1 cycles.
- res holds its last value while out_valid=0. A new result loads only when a valid entry arrives.
- Back-to-back in_valid on every cycle must yield out_valid on every cycle, with order preserved.
- in_valid=0 cycles propagate as bubbles. p is ignored when the aligned entry is invalid.

Decomposition:
- Shared package fdiv_pkg:
  - EXP_BIAS=127, EXP_MAX=255
  - QNAN=32'h7FC00000, POS_INF=32'h7F800000
  - struct fdiv_side_t {s, ex, ey, rz, xz, yz, xi, yi}
  - function classifying an operand into its zero/inf flags
- One sub-module: fdiv_side_delay. Parametric (DEPTH=MUL_LAT) shift register of {valid, fdiv_side_t} with async active-low clear.

Test Plan:
- 6.0/2.0: x=0x40C00000, y=0x40000000, p=0x3FC00000 at +MUL_LAT -> res=0x40400000, out_valid exactly MUL_LAT+1 cycles after in_valid.
- 1.0/3.0: x=0x3F800000, y=0x40400000, p=0x3FAAAAAB -> res=0x3EAAAAAB. Repeat with x=0xBF800000 -> res=0xBEAAAAAB.
- Overflow/underflow:
  - x=0x7F000000, y=0x3E800000, p=0x3F800000 -> res=0x7F800000
  - x=0x00800000, y=0x40000000, p=0x3F800000 -> res=0x00000000
- Specials:
  - 0/0 -> 0x7FC00000
  - 1.0/0 -> 0x7F800000
  - -1.0/+inf (0x7F800000) -> 0x80000000
  - 0x00400000 (denormal)/1.0 -> 0x00000000
- Streaming: 8 consecutive in_valid cycles with distinct operands, then 2 idle, then 3 more -> 11 results, in order, with identical bubble pattern and latency.
- Reset mid-flight: in_valid for 2 cycles, assert rstn=0 asynchronously between clock edges -> out_valid and res go to 0 immediately; no result emerges after release.
